// File: rtl/ifid_pkg.sv
// IF/ID register support: occupancy-state encoding and the default NOP word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifid_pkg;

    // The encoding doubles as the occupancy count, so occupancy is a plain copy of the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } ifid_state_e;

    localparam logic [31:0] IFID_NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a two-entry skid buffer (MAIN drives decode, SKID absorbs one stall).
// Latency: accept in cycle N is visible on instr_out/pc_out with out_valid=1 in cycle N+1.
// Backpressure: in_ready comes from the state register only, and drops once both entries are held.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   flush             squash held entries; the output becomes NOP and pc_out holds
//   in_valid/in_ready fetch-side handshake carrying instr_in/pc_in
//   out_valid/out_ready decode-side handshake carrying instr_out/pc_out
//   occupancy         number of entries held (0..2)
module ifid_skid_reg
    import ifid_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 ADDR_W    = 7,
    parameter logic [INSTR_W-1:0] NOP_INSTR = IFID_NOP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [1:0]         occupancy
);

    ifid_state_e        state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [ADDR_W-1:0]  main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;

    logic accept;
    logic consume;

    // Both handshake outputs are decoded from the state flop alone, so neither has an input-to-output path.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign instr_out = main_instr_q;
    assign pc_out    = main_pc_q;
    assign occupancy = state_q;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            // The handshake completes, but the data is dropped. pc_out keeps the squashed address.
            state_d      = ST_EMPTY;
            main_instr_d = NOP_INSTR;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_instr_d = instr_in;
                        main_pc_d    = pc_in;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_instr_d = instr_in;
                        main_pc_d    = pc_in;
                    end else if (accept) begin
                        // Decode stalled. Park the newcomer behind MAIN.
                        skid_instr_d = instr_in;
                        skid_pc_d    = pc_in;
                        state_d      = ST_FULL;
                    end else if (consume) begin
                        // MAIN keeps the consumed value, so the outputs hold while the register is empty.
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        state_d      = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule

// File: doc/ifid_skid_reg.md
# ifid_skid_reg

Parametrised IF/ID pipeline register carrying the fetched instruction and its address from fetch to decode, with a valid/ready handshake on both sides. A two-entry skid buffer absorbs one cycle of decode backpressure while keeping `in_ready` free of any combinational path from `out_ready`. A synchronous flush squashes in-flight instructions and substitutes a NOP on the output for branch/jump redirects.

## Interface
- `INSTR_W`, 32, instruction width in bits
- `ADDR_W`, 7, instruction address width in bits
- `NOP_INSTR`, 32'h0000_0000, value driven on `instr_out` after reset/flush (width `INSTR_W`)
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  squash all held entries
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  register can accept this cycle
- `instr_in`  in  INSTR_W  fetched instruction
- `pc_in`  in  ADDR_W  address of `instr_in`
- `out_valid`  out  1  decode-side data valid
- `out_ready`  in  1  decode consumes this cycle
- `instr_out`  out  INSTR_W  instruction to decode
- `pc_out`  out  ADDR_W  address of `instr_out`
- `occupancy`  out  2  entries held (0..2)

## Operation
- Entries: MAIN (drives outputs) and SKID. States EMPTY (0 entries), ONE, FULL (2).
- Accept = `in_valid && in_ready`; consume = `out_valid && out_ready`.
- `in_ready` = (state != FULL), decoded from state register only. `out_valid` = (state != EMPTY).
- EMPTY: accept -> MAIN <= input, go ONE.
- ONE: accept & consume -> MAIN <= input, stay ONE; accept & !consume -> SKID <= input, go FULL; consume & !accept -> EMPTY; neither -> hold.
- FULL: consume -> MAIN <= SKID, go ONE; otherwise hold. No accept possible.
- Order preserved: instructions leave in acceptance order; no duplication, no loss except by flush/reset.
- Priority: `rst` > `flush` > normal handshake.
- `flush`: next state EMPTY, both entries invalidated, `instr_out` <= `NOP_INSTR`, `pc_out` holds its value. An accept or consume in the flush cycle completes the handshake but the incoming data is discarded.
- `rst`: state EMPTY, `instr_out` = `NOP_INSTR`, `pc_out` = 0, SKID contents don't-care. Transfers in a reset cycle are discarded.
- While `out_valid`=0, `instr_out`/`pc_out` hold last value (NOP after flush/reset).
- `occupancy` = 0/1/2 for EMPTY/ONE/FULL.

## Timing
- Latency: accept in cycle N -> visible on outputs with `out_valid`=1 in cycle N+1 (from EMPTY or ONE-with-consume).
- Throughput: 1 instruction/cycle with `out_ready` held high.
- `out_ready` low for k cycles: at most one further accept after MAIN fills, then `in_ready`=0 from the next cycle.
- `in_ready` and `out_valid` change only after a clock edge; neither depends combinationally on any input.
- Reset values: `in_ready`=1, `out_valid`=0, `instr_out`=`NOP_INSTR`, `pc_out`=0, `occupancy`=0.
- Reset or flush asserted mid-stall (FULL): EMPTY on the next edge, `in_ready`=1 immediately after.

## Structure
- Package `ifid_pkg`: state enum (EMPTY, ONE, FULL) and default NOP constant.
- Single module; no sub-module. MAIN/SKID are plain register pairs; the MAIN load mux selects input or SKID.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1, `instr_in`=128 -> `out_valid`=0, `instr_out`=NOP, `pc_out`=0, `occupancy`=0 afterwards.
- Streaming: `out_ready`=1, feed (128,pc 1),(532,8),(1250,109) on consecutive cycles -> same triples on outputs, each one cycle later, `occupancy` stays 1.
- Backpressure: `out_ready`=0 while feeding 128/1, 532/8, 1250/109 -> first two held, `in_ready`=0 from cycle 3, 1250 not accepted until `out_ready` rises; then outputs 128, 532, 1250 in order.
- Flush while FULL with an accept attempted the same cycle -> EMPTY next cycle, `instr_out`=NOP, `pc_out` unchanged, flushed and concurrent data never appear.
- Simultaneous accept and consume in ONE -> `occupancy` stays 1, output advances to new instruction, none lost.
- Reset asserted while FULL -> all outputs at reset values next cycle, subsequent stream 532/8 passes normally.
